// File: rtl/fifo_flex.sv
// fifo_flex: single-clock ready/valid FIFO with first-word-fall-through output,
// occupancy count, almost-full/almost-empty flags, synchronous flush and
// sticky overflow/underflow debug flags.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   enq_valid/ready    producer handshake, enq_data is the write word
//   deq_valid/ready    consumer handshake, deq_data is the head word
//   flush              synchronous discard of all contents
//   count              occupancy, 0..DEPTH
//   almost_full/empty  count >= AF_THRESH / count <= AE_THRESH
//   overflow/underflow sticky: enq while full / deq while empty
//   err_clr            synchronous clear of the sticky flags
module fifo_flex #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LOGDEPTH  = 3,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq_valid,
    input  logic [WIDTH-1:0]    enq_data,
    output logic                enq_ready,
    output logic                deq_valid,
    output logic [WIDTH-1:0]    deq_data,
    input  logic                deq_ready,
    input  logic                flush,
    output logic [LOGDEPTH:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow,
    input  logic                err_clr
);

    localparam int unsigned        DEPTH    = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0]  CNT_FULL = (LOGDEPTH+1)'(DEPTH);
    localparam logic [LOGDEPTH:0]  CNT_AF   = (LOGDEPTH+1)'(AF_THRESH);
    localparam logic [LOGDEPTH:0]  CNT_AE   = (LOGDEPTH+1)'(AE_THRESH);
    localparam logic [LOGDEPTH:0]  CNT_ONE  = (LOGDEPTH+1)'(1);
    localparam logic [LOGDEPTH-1:0] PTR_ONE = LOGDEPTH'(1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOGDEPTH:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                enq_fire, deq_fire;

    // Handshake outputs depend only on registered occupancy.
    assign enq_ready    = (count_q != CNT_FULL);
    assign deq_valid    = (count_q != '0);
    assign deq_data     = mem[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush suppresses both transfers for the cycle.
    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A fresh error in the same cycle as err_clr keeps the flag set.
            if (enq_valid && !enq_ready) overflow_d  = 1'b1;
            if (deq_ready && !deq_valid) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr_q] <= enq_data;
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: stimulus pushes expected words into exp_q,
// an independent monitor pops and compares on every dequeue handshake.
module tb_fifo_flex;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_data = '0;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_data;
    logic        deq_ready = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  count;
    logic        almost_full, almost_empty, overflow, underflow;
    logic        err_clr = 1'b0;

    int n_vec  = 0;
    int n_err  = 0;
    int n_recv = 0;
    logic [31:0] exp_q[$];

    fifo_flex #(
        .WIDTH(32), .LOGDEPTH(3), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
        .flush(flush), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every word actually handed to the consumer.
    always @(negedge clk) begin
        if (!rst && !flush && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL deq_unexpected: got %0d expected no word", deq_data);
            end else begin
                check("deq_data", deq_data, exp_q.pop_front());
            end
            n_recv++;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_enq_ready"}, 32'(enq_ready), 1);
        check({tag, "_deq_valid"}, 32'(deq_valid), 0);
        check({tag, "_ae"}, 32'(almost_empty), 1);
        check({tag, "_af"}, 32'(almost_full), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'(base + i);
            exp_q.push_back(32'(base + i));
            tick();
        end
        enq_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        deq_ready = 1'b1;
        repeat (n) tick();
        deq_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

        // 1: fill to full with flag tracking, then drain in order
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'(1000 + i);
            exp_q.push_back(32'(1000 + i));
            tick();
            check("t1_count", 32'(count), 32'(i + 1));
            check("t1_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            check("t1_ae", 32'(almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
        end
        enq_valid = 1'b0;
        check("t1_enq_ready_full", 32'(enq_ready), 0);
        drain(8);
        check("t1_deq_valid", 32'(deq_valid), 0);
        check("t1_count_end", 32'(count), 0);
        check("t1_ovf", 32'(overflow), 0);
        check("t1_udf", 32'(underflow), 0);

        // 2: overflow on full FIFO, contents preserved, err_clr behaviour
        fill(8, 1000);
        enq_valid = 1'b1;
        enq_data  = 32'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_count", 32'(count), 8);
        end
        check("t2_ovf", 32'(overflow), 1);
        err_clr = 1'b1;
        tick();
        check("t2_ovf_clr_vs_new", 32'(overflow), 1);
        enq_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        check("t2_ovf_cleared", 32'(overflow), 0);
        drain(8);
        check("t2_count_end", 32'(count), 0);

        // 3: underflow on empty FIFO
        deq_ready = 1'b1;
        repeat (10) tick();
        deq_ready = 1'b0;
        check("t3_count", 32'(count), 0);
        check("t3_udf", 32'(underflow), 1);
        check("t3_enq_ready", 32'(enq_ready), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_udf_cleared", 32'(underflow), 0);

        // 4: concurrent stream with periodic 2-cycle read stalls
        n_recv = 0;
        fork
            begin
                int i;
                i = 0;
                for (int c = 0; c < 600 && i < 50; c++) begin
                    if (enq_ready) begin
                        enq_valid = 1'b1;
                        enq_data  = 32'(1000 + i);
                        exp_q.push_back(32'(1000 + i));
                        i++;
                    end else begin
                        enq_valid = 1'b0;
                    end
                    tick();
                end
                enq_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 800 && n_recv < 50; c++) begin
                    deq_ready = ((c % 5) < 3) && deq_valid;
                    tick();
                end
                deq_ready = 1'b0;
            end
        join
        check("t4_received", 32'(n_recv), 50);
        check("t4_ovf", 32'(overflow), 0);
        check("t4_udf", 32'(underflow), 0);
        check("t4_count_end", 32'(count), 0);

        // 5: flush overrides concurrent enq/deq
        fill(5, 1100);
        check("t5_count_pre", 32'(count), 5);
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 32'd9999;
        deq_ready = 1'b1;
        exp_q.delete();
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("t5_count", 32'(count), 0);
        check("t5_deq_valid", 32'(deq_valid), 0);
        check("t5_ovf", 32'(overflow), 0);
        check("t5_udf", 32'(underflow), 0);
        fill(1, 1234);
        check("t5_count_one", 32'(count), 1);
        drain(1);
        check("t5_count_end", 32'(count), 0);

        // 6: asynchronous reset mid-stream clears state and flags at once
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check("t6_udf_set", 32'(underflow), 1);
        fill(4, 1300);
        check("t6_count_pre", 32'(count), 4);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_reset_state("t6");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t6_count_after", 32'(count), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
